// File: rtl/simple_rom_loader_if.sv
// Byte-stream input, load control and memory write port of the ROM loader.
// The master side is the host/byte source plus the RAM write port observer;
// the slave side is the loader itself.
interface simple_rom_loader_if #(
  parameter int width   = 32,
  parameter int widthad = 8
);
  logic               start;
  logic [widthad-1:0] start_addr;
  logic [widthad:0]   word_count;
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               wr_en;
  logic [widthad-1:0] wr_addr;
  logic [width-1:0]   wr_data;
  logic               busy;
  logic               done;

  modport master (
    output start, start_addr, word_count, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, start_addr, word_count, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/simple_rom_loader.sv
// Run-time memory image loader: packs an 8-bit byte stream little-endian into
// width-bit words and issues one registered write per completed word,
// starting at a captured base address.
module simple_rom_loader #(
  parameter int width   = 32,
  parameter int widthad = 8
) (
  input logic               clk,
  input logic               rst,
  simple_rom_loader_if.slave bus
);
  localparam int BPW   = width / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, LAST, DONE} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   byte_idx;
  logic [widthad:0]   remaining;
  logic [widthad-1:0] addr;
  logic [width-1:0]   pack, pack_next;
  logic               wr_en_q, busy_q, done_q;
  logic [widthad-1:0] wr_addr_q;
  logic [width-1:0]   wr_data_q;
  logic               accept, word_done;

  // in_ready depends on state only, so a source may legally wait for it
  assign bus.in_ready = (state == LOAD);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  assign accept    = (state == LOAD) && bus.in_valid;
  assign word_done = accept && (byte_idx == IDX_W'(BPW - 1));

  // Next-state decode and the pack word with the incoming byte merged in
  always_comb begin
    state_next = state;
    pack_next  = pack;
    pack_next[8*byte_idx +: 8] = bus.in_data;
    case (state)
      IDLE: if (bus.start) state_next = (bus.word_count == '0) ? DONE : LOAD;
      LOAD: if (word_done && (remaining == (widthad+1)'(1))) state_next = LAST;
      LAST: state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Parameter capture, byte packing, address/count stepping and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx  <= '0;
      remaining <= '0;
      addr      <= '0;
      pack      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      busy_q  <= (state_next == LOAD) || (state_next == LAST);
      done_q  <= (state_next == DONE);
      if ((state == IDLE) && bus.start) begin
        addr      <= bus.start_addr;
        remaining <= bus.word_count;
        pack      <= '0;
        byte_idx  <= '0;
      end else if (accept) begin
        if (word_done) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= addr;
          wr_data_q <= pack_next;
          addr      <= addr + widthad'(1);
          remaining <= remaining - (widthad+1)'(1);
          pack      <= '0;
          byte_idx  <= '0;
        end else begin
          pack     <= pack_next;
          byte_idx <= byte_idx + IDX_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_simple_rom_loader.sv
// Directed bench for simple_rom_loader with width=32, widthad=4.
module tb_simple_rom_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;

  simple_rom_loader_if #(.width(32), .widthad(4)) bus ();

  simple_rom_loader #(.width(32), .widthad(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]        start_addr;
    logic [4:0]        word_count;
    logic              gap;
    logic              poke;
    logic [2:0][3:0]   exp_addr;
    logic [2:0][31:0]  exp_data;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  vec_t vecs [6];
  logic [7:0] stream [12];

  // Count every write strobe seen by the memory
  always @(negedge clk) if (bus.wr_en) wr_count++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] a, input logic [4:0] n, input logic g, input logic p,
                              input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    vec_t v;
    v.start_addr  = a;
    v.word_count  = n;
    v.gap         = g;
    v.poke        = p;
    v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2;
    v.exp_data[0] = d0; v.exp_data[1] = d1; v.exp_data[2] = d2;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int   byte_i, nbytes, cyc, w;
    logic acc;
    nbytes = 4 * int'(v.word_count);
    bus.start      = 1'b1;
    bus.start_addr = v.start_addr;
    bus.word_count = v.word_count;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.start_addr = 4'hA;
    bus.word_count = 5'd5;
    if (v.word_count == 5'd0) begin
      chk("zero_done", 32'(bus.done), 32'd1);
      chk("zero_wr_en", 32'(bus.wr_en), 32'd0);
      chk("zero_in_ready", 32'(bus.in_ready), 32'd0);
      chk("zero_busy", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      chk("zero_done_drop", 32'(bus.done), 32'd0);
      chk("zero_in_ready_idle", 32'(bus.in_ready), 32'd0);
      chk("zero_wr_en_idle", 32'(bus.wr_en), 32'd0);
      return;
    end
    chk("load_busy", 32'(bus.busy), 32'd1);
    chk("load_in_ready", 32'(bus.in_ready), 32'd1);
    byte_i = 0;
    cyc    = 0;
    while (byte_i < nbytes && cyc < 200) begin
      bus.in_valid = v.gap ? ((cyc % 2) == 0) : 1'b1;
      bus.in_data  = stream[byte_i];
      if (v.poke && byte_i == 2) begin
        bus.start      = 1'b1;
        bus.start_addr = 4'd9;
        bus.word_count = 5'd1;
      end else begin
        bus.start = 1'b0;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc && (byte_i % 4) == 3) begin
        w = byte_i / 4;
        chk("wr_en_word", 32'(bus.wr_en), 32'd1);
        chk("wr_addr", 32'(bus.wr_addr), 32'(v.exp_addr[w]));
        chk("wr_data", bus.wr_data, v.exp_data[w]);
      end else begin
        chk("no_extra_wr_en", 32'(bus.wr_en), 32'd0);
      end
      if (acc) byte_i++;
    end
    bus.start = 1'b0;
    chk("bytes_accepted", 32'(byte_i), 32'(nbytes));
    chk("last_in_ready", 32'(bus.in_ready), 32'd0);
    chk("last_busy", 32'(bus.busy), 32'd1);
    chk("last_done", 32'(bus.done), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    @(posedge clk); #1;
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("done_wr_en", 32'(bus.wr_en), 32'd0);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("done_drop", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_wr_en", 32'(bus.wr_en), 32'd0);
  endtask

  initial begin
    int wr_base;
    for (int i = 0; i < 12; i++) stream[i] = 8'((i + 1) * 17);

    vecs[0] = mk(4'd3, 5'd2, 1'b0, 1'b0, 4'd3, 4'd4, 4'd0, 32'h44332211, 32'h88776655, 32'h0);
    vecs[1] = mk(4'd3, 5'd2, 1'b1, 1'b0, 4'd3, 4'd4, 4'd0, 32'h44332211, 32'h88776655, 32'h0);
    vecs[2] = mk(4'd15, 5'd3, 1'b0, 1'b0, 4'd15, 4'd0, 4'd1, 32'h44332211, 32'h88776655, 32'hCCBBAA99);
    vecs[3] = mk(4'd7, 5'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0);
    vecs[4] = mk(4'd3, 5'd2, 1'b0, 1'b1, 4'd3, 4'd4, 4'd0, 32'h44332211, 32'h88776655, 32'h0);
    vecs[5] = mk(4'd0, 5'd1, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 32'h44332211, 32'h0, 32'h0);

    bus.start      = 1'b0;
    bus.start_addr = '0;
    bus.word_count = '0;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_wr_data", bus.wr_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      wr_base = wr_count;
      run_vec(vecs[i]);
      chk("write_count", 32'(wr_count - wr_base), 32'(vecs[i].word_count));
    end

    // Reset after 6 bytes of a 2-word load
    wr_base = wr_count;
    bus.start      = 1'b1;
    bus.start_addr = 4'd3;
    bus.word_count = 5'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = stream[i];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("abort_busy_before", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_wr_en", 32'(bus.wr_en), 32'd0);
    chk("abort_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("abort_wr_data", bus.wr_data, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    chk("abort_writes", 32'(wr_count - wr_base), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle_no_done", 32'(bus.done), 32'd0);
    wr_base = wr_count;
    run_vec(vecs[0]);
    chk("reload_writes", 32'(wr_count - wr_base), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
